// File: rtl/text_cell_addr_gen_pkg.sv
// Shared constants and types for the text-mode character cell address generator.
// Holds default widths/geometry and the scroll-base FSM state encoding.
package text_pkg;

    localparam int DEF_CTR_W   = 11;
    localparam int DEF_GEO_W   = 8;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_GLYPH_W = 8;
    localparam int DEF_GLYPH_H = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } scroll_state_e;

endpackage

// File: rtl/text_cell_addr_gen_if.sv
// Timing-in / cell-address-out bundle of the text cell address generator.
// master drives timing and geometry, slave is the generator itself.
interface text_cell_addr_gen_if
    import text_pkg::*;
#(
    parameter int CTR_W   = DEF_CTR_W,
    parameter int GEO_W   = DEF_GEO_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int GLYPH_W = DEF_GLYPH_W,
    parameter int GLYPH_H = DEF_GLYPH_H
);
    localparam int GX_W = $clog2(GLYPH_W);
    localparam int GY_W = $clog2(GLYPH_H);

    logic [CTR_W-1:0]  hctr_in;
    logic [CTR_W-1:0]  vctr_in;
    logic              hsync_in;
    logic              vsync_in;
    logic              de_in;
    logic [GEO_W-1:0]  max_columns;
    logic [GEO_W-1:0]  max_rows;
    logic [GEO_W-1:0]  scroll_row;

    logic [ADDR_W-1:0] address_out;
    logic [GX_W-1:0]   glyph_x;
    logic [GY_W-1:0]   glyph_y;
    logic              cell_valid;
    logic              hsync_out;
    logic              vsync_out;
    logic              de_out;
    logic              scroll_busy;

    modport master (
        output hctr_in, vctr_in, hsync_in, vsync_in, de_in,
        output max_columns, max_rows, scroll_row,
        input  address_out, glyph_x, glyph_y, cell_valid,
        input  hsync_out, vsync_out, de_out, scroll_busy
    );

    modport slave (
        input  hctr_in, vctr_in, hsync_in, vsync_in, de_in,
        input  max_columns, max_rows, scroll_row,
        output address_out, glyph_x, glyph_y, cell_valid,
        output hsync_out, vsync_out, de_out, scroll_busy
    );

endinterface

// File: rtl/scroll_base_calc.sv
// Computes the per-frame scroll base (scroll_row * columns) by repeated
// addition, started by a vsync rising edge and committed when done.
module scroll_base_calc
    import text_pkg::*;
#(
    parameter int GEO_W  = DEF_GEO_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync_in,
    input  logic [GEO_W-1:0]  scroll_row,
    input  logic [GEO_W-1:0]  max_columns,
    input  logic [GEO_W-1:0]  max_rows,
    output logic [ADDR_W-1:0] base_out,
    output logic [GEO_W-1:0]  row_out,
    output logic              busy
);

    scroll_state_e     state_q;
    logic              vs_prev_q;
    logic [ADDR_W-1:0] acc_q;
    logic [GEO_W-1:0]  cnt_q;
    logic [GEO_W-1:0]  lat_row_q;
    logic [GEO_W-1:0]  lat_cols_q;
    logic [ADDR_W-1:0] base_q;
    logic [GEO_W-1:0]  row_q;
    logic              busy_q;

    logic [GEO_W-1:0]  row_clamp;
    logic              vs_rise;

    // An out-of-range scroll row falls back to the top of the buffer
    always_comb begin
        row_clamp = (scroll_row >= max_rows) ? '0 : scroll_row;
        vs_rise   = vsync_in && !vs_prev_q;
    end

    // Repeated-add FSM; committed base/row only change in COMMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vs_prev_q  <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            lat_row_q  <= '0;
            lat_cols_q <= '0;
            base_q     <= '0;
            row_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            vs_prev_q <= vsync_in;
            unique case (state_q)
                S_IDLE: begin
                    if (vs_rise) begin
                        lat_row_q  <= row_clamp;
                        lat_cols_q <= max_columns;
                        cnt_q      <= row_clamp;
                        acc_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt_q == '0) begin
                        state_q <= S_COMMIT;
                    end else begin
                        acc_q <= acc_q + ADDR_W'(lat_cols_q);
                        cnt_q <= cnt_q - GEO_W'(1);
                    end
                end
                S_COMMIT: begin
                    base_q  <= acc_q;
                    row_q   <= lat_row_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign base_out = base_q;
    assign row_out  = row_q;
    assign busy     = busy_q;

endmodule

// File: rtl/text_cell_addr_gen.sv
// Character-cell address generator: incremental glyph/cell tracking with
// hardware vertical scroll, two registered stages from timing to outputs.
module text_cell_addr_gen
    import text_pkg::*;
#(
    parameter int CTR_W   = DEF_CTR_W,
    parameter int GLYPH_W = DEF_GLYPH_W,
    parameter int GLYPH_H = DEF_GLYPH_H,
    parameter int GEO_W   = DEF_GEO_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                 CLK_108MHz,
    input  logic                 reset,
    text_cell_addr_gen_if.slave  bus
);

    localparam int GX_W = $clog2(GLYPH_W);
    localparam int GY_W = $clog2(GLYPH_H);

    localparam logic [GX_W-1:0]  SUBX_MAX = GX_W'(GLYPH_W - 1);
    localparam logic [GY_W-1:0]  SUBY_MAX = GY_W'(GLYPH_H - 1);
    localparam logic [GEO_W-1:0] GEO_MAX  = '1;

    logic [ADDR_W-1:0] commit_base;
    logic [GEO_W-1:0]  commit_row;
    logic              busy;

    scroll_base_calc #(
        .GEO_W  (GEO_W),
        .ADDR_W (ADDR_W)
    ) u_scroll (
        .clk         (CLK_108MHz),
        .rst         (reset),
        .vsync_in    (bus.vsync_in),
        .scroll_row  (bus.scroll_row),
        .max_columns (bus.max_columns),
        .max_rows    (bus.max_rows),
        .base_out    (commit_base),
        .row_out     (commit_row),
        .busy        (busy)
    );

    // Stage 1 state
    logic [GX_W-1:0]   sub_x_q, sub_x_d;
    logic [GEO_W-1:0]  col_q, col_d;
    logic [GY_W-1:0]   sub_y_q, sub_y_d;
    logic [GEO_W-1:0]  row_q, row_d;
    logic [GEO_W-1:0]  phys_row_q, phys_row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [GEO_W-1:0]  cols_q, cols_d;
    logic [GEO_W-1:0]  rows_q, rows_d;
    logic [2:0]        strb1_q, strb1_d;

    // Stage 2 (output) state
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [GX_W-1:0]   gx_q, gx_d;
    logic [GY_W-1:0]   gy_q, gy_d;
    logic              valid_q, valid_d;
    logic [2:0]        strb2_q, strb2_d;

    logic line_start;
    logic frame_start;

    // Stage 1 next state: glyph/cell counters and scrolled row base
    always_comb begin
        sub_x_d    = sub_x_q;
        col_d      = col_q;
        sub_y_d    = sub_y_q;
        row_d      = row_q;
        phys_row_d = phys_row_q;
        row_base_d = row_base_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        strb1_d    = {bus.hsync_in, bus.vsync_in, bus.de_in};

        line_start  = (bus.hctr_in == '0);
        frame_start = line_start && (bus.vctr_in == '0);

        if (line_start) begin
            sub_x_d = '0;
            col_d   = '0;
        end else if (sub_x_q == SUBX_MAX) begin
            sub_x_d = '0;
            if (col_q != GEO_MAX) begin
                col_d = col_q + GEO_W'(1);
            end
        end else begin
            sub_x_d = sub_x_q + GX_W'(1);
        end

        if (frame_start) begin
            sub_y_d    = '0;
            row_d      = '0;
            phys_row_d = commit_row;
            row_base_d = commit_base;
            cols_d     = bus.max_columns;
            rows_d     = bus.max_rows;
        end else if (line_start) begin
            if (sub_y_q < SUBY_MAX) begin
                sub_y_d = sub_y_q + GY_W'(1);
            end else begin
                sub_y_d = '0;
                if (row_q != GEO_MAX) begin
                    row_d = row_q + GEO_W'(1);
                end
                if (phys_row_q == rows_q - GEO_W'(1)) begin
                    phys_row_d = '0;
                    row_base_d = '0;
                end else begin
                    phys_row_d = phys_row_q + GEO_W'(1);
                    row_base_d = row_base_q + ADDR_W'(cols_q);
                end
            end
        end
    end

    // Stage 2 next state: address, validity, glyph position, strobes
    always_comb begin
        addr_d  = row_base_q + ADDR_W'(col_q);
        valid_d = (col_q < cols_q) && (row_q < rows_q);
        gx_d    = sub_x_q;
        gy_d    = sub_y_q;
        strb2_d = strb1_q;
    end

    // Pipeline registers
    always_ff @(posedge CLK_108MHz or posedge reset) begin
        if (reset) begin
            sub_x_q    <= '0;
            col_q      <= '0;
            sub_y_q    <= '0;
            row_q      <= '0;
            phys_row_q <= '0;
            row_base_q <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            strb1_q    <= '0;
            addr_q     <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            valid_q    <= 1'b0;
            strb2_q    <= '0;
        end else begin
            sub_x_q    <= sub_x_d;
            col_q      <= col_d;
            sub_y_q    <= sub_y_d;
            row_q      <= row_d;
            phys_row_q <= phys_row_d;
            row_base_q <= row_base_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            strb1_q    <= strb1_d;
            addr_q     <= addr_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            valid_q    <= valid_d;
            strb2_q    <= strb2_d;
        end
    end

    assign bus.address_out = addr_q;
    assign bus.glyph_x     = gx_q;
    assign bus.glyph_y     = gy_q;
    assign bus.cell_valid  = valid_q;
    assign bus.hsync_out   = strb2_q[2];
    assign bus.vsync_out   = strb2_q[1];
    assign bus.de_out      = strb2_q[0];
    assign bus.scroll_busy = busy;

endmodule

// File: tb/tb_text_cell_addr_gen.sv
// Directed bench for text_cell_addr_gen: default 8x8 glyph instance plus a
// 6x12 glyph instance, both fed the same timing and geometry.
module tb_text_cell_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hctr = '0;
    logic [10:0] vctr = '0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic        de = 1'b0;
    logic [7:0]  cols = 8'd160;
    logic [7:0]  rows = 8'd128;
    logic [7:0]  scroll = 8'd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    text_cell_addr_gen_if ifa ();
    text_cell_addr_gen_if #(.GLYPH_W(6), .GLYPH_H(12)) ifb ();

    assign ifa.hctr_in     = hctr;
    assign ifa.vctr_in     = vctr;
    assign ifa.hsync_in    = hs;
    assign ifa.vsync_in    = vs;
    assign ifa.de_in       = de;
    assign ifa.max_columns = cols;
    assign ifa.max_rows    = rows;
    assign ifa.scroll_row  = scroll;
    assign ifb.hctr_in     = hctr;
    assign ifb.vctr_in     = vctr;
    assign ifb.hsync_in    = hs;
    assign ifb.vsync_in    = vs;
    assign ifb.de_in       = de;
    assign ifb.max_columns = cols;
    assign ifb.max_rows    = rows;
    assign ifb.scroll_row  = scroll;

    text_cell_addr_gen u_a (
        .CLK_108MHz (clk),
        .reset      (rst),
        .bus        (ifa)
    );

    text_cell_addr_gen #(.GLYPH_W(6), .GLYPH_H(12)) u_b (
        .CLK_108MHz (clk),
        .reset      (rst),
        .bus        (ifb)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given counters; de/hsync follow hctr bits
    task automatic drive(input int h, input int v);
        hctr = 11'(h);
        vctr = 11'(v);
        de   = (h % 2) == 1;
        hs   = ((h / 2) % 2) == 1;
        @(posedge clk);
        #1;
    endtask

    // Frame start, line starts down to v, count across to h, then one
    // extra clock so the outputs show sample (v, h)
    task automatic go_to(input int v, input int h);
        drive(0, 0);
        for (int j = 1; j <= v; j++) drive(0, j);
        for (int i = 1; i <= h; i++) drive(i, v);
        drive(h + 1, v);
    endtask

    // vsync rising edge with scroll row sr; a second edge carrying sr2 is
    // offered on the second busy cycle. Returns busy cycle count.
    task automatic scroll_run(input int sr, input int sr2, output int n);
        n = 0;
        scroll = 8'(sr);
        vs = 1'b1;
        drive(100, 500);
        while (ifa.scroll_busy && n < 300) begin
            n++;
            if (n == 2) begin
                scroll = 8'(sr2);
                vs = 1'b1;
            end else begin
                vs = 1'b0;
            end
            drive(100 + n, 500);
        end
        vs = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", ifa.address_out, 0);
        check("rst_valid", ifa.cell_valid, 0);
        check("rst_busy", ifa.scroll_busy, 0);
        check("rst_gx", ifa.glyph_x, 0);
        rst = 1'b0;

        go_to(8, 17);
        check("a_addr_8_17", ifa.address_out, 162);
        check("a_gx_8_17", ifa.glyph_x, 1);
        check("a_gy_8_17", ifa.glyph_y, 0);
        check("a_valid_8_17", ifa.cell_valid, 1);
        check("a_de_8_17", ifa.de_out, 1);
        check("a_hs_8_17", ifa.hsync_out, 0);

        go_to(12, 6);
        check("b_addr_12_6", ifb.address_out, 161);
        check("b_gx_12_6", ifb.glyph_x, 0);
        check("b_gy_12_6", ifb.glyph_y, 0);
        check("b_valid_12_6", ifb.cell_valid, 1);
        check("b_hs_12_6", ifb.hsync_out, 1);

        scroll_run(5, 5, n);
        check("busy_len_5", n, 7);
        go_to(0, 0);
        check("scr5_top", ifa.address_out, 800);
        check("scr5_top_valid", ifa.cell_valid, 1);
        go_to(984, 0);
        check("scr5_wrap", ifa.address_out, 0);
        go_to(992, 0);
        check("scr5_after_wrap", ifa.address_out, 160);
        go_to(1024, 0);
        check("row_oob_valid", ifa.cell_valid, 0);
        go_to(0, 1279);
        check("last_col_addr", ifa.address_out, 959);
        check("last_col_valid", ifa.cell_valid, 1);
        go_to(0, 1280);
        check("col_oob_valid", ifa.cell_valid, 0);

        scroll_run(200, 200, n);
        check("busy_len_clamp", n, 2);
        go_to(0, 0);
        check("clamp_base", ifa.address_out, 0);

        scroll_run(3, 255, n);
        check("busy_len_ignore", n, 5);
        drive(300, 500);
        drive(301, 500);
        check("no_restart", ifa.scroll_busy, 0);
        go_to(0, 0);
        check("scr3_base", ifa.address_out, 480);

        go_to(8, 3);
        check("pre_rst_addr", ifa.address_out, 640);
        check("pre_rst_gx", ifa.glyph_x, 3);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_addr", ifa.address_out, 0);
        check("async_rst_gx", ifa.glyph_x, 0);
        check("async_rst_valid", ifa.cell_valid, 0);
        check("async_rst_de", ifa.de_out, 0);
        #2;
        rst = 1'b0;
        go_to(0, 9);
        check("post_rst_addr", ifa.address_out, 1);
        check("post_rst_gx", ifa.glyph_x, 1);
        check("post_rst_valid", ifa.cell_valid, 1);
        go_to(8, 0);
        check("post_rst_row1", ifa.address_out, 160);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
